coffee_vend_ctrl: RTL and testbench

Parametrised successor to the single-price coffee machine controller. Accepts 0.25/0.50/1.00 coins and accumulates credit in quarter units. Dispenses coffee when credit reaches a configurable price, then returns change as a train of quarter pulses. Adds a cancel/refund path, coin rejection on overflow or while busy, and a configurable dispense pulse length. Sits between the coin acceptor front-end and the brewer/coin-return actuators.

---
 rtl/coffee_vend_pkg.sv | 27 ++
 rtl/coffee_vend_ctrl_timer.sv | 33 +++
 rtl/coffee_vend_ctrl.sv | 119 +++++++++++
 tb/tb_coffee_vend_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/coffee_vend_pkg.sv
// Shared types and helpers for the coffee vending controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package coffee_vend_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } state_t;

    localparam int unsigned COIN025_UNITS = 1;
    localparam int unsigned COIN05_UNITS  = 2;
    localparam int unsigned COIN1_UNITS   = 4;

    // Value of the coins sampled in one cycle, in quarter units (0..7).
    function automatic logic [2:0] coin_sum(input logic in025, input logic in05, input logic in1);
        logic [2:0] s;
        s = 3'd0;
        if (in025) s = s + 3'(COIN025_UNITS);
        if (in05)  s = s + 3'(COIN05_UNITS);
        if (in1)   s = s + 3'(COIN1_UNITS);
        return s;
    endfunction

endpackage

// File: rtl/coffee_vend_ctrl_timer.sv
// Loadable down-counter that times the dispense strobe; done = count exhausted.
// Latency: load takes effect on the next edge; done is combinational from the count.
// Backpressure: none; counts only while en is high.
//   ports: clock, reset (async active-low), load, load_val, en, done
module vend_pulse_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (en && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/coffee_vend_ctrl.sv
// Coin-credit vending controller: collects quarters, dispenses at PRICE_UNITS, refunds change.
// Latency: all outputs registered; sai_cafe rises on the edge that accepts the final coin.
// Backpressure: coins that cannot be credited (overflow, busy, cancel) are flagged by coin_reject.
//   ports: clock, reset (async active-low), money_in025/05/1, cancel ->
//          sai_cafe, coin_out025, coin_reject, credit[CREDIT_W-1:0], busy
module coffee_vend_ctrl
    import coffee_vend_pkg::*;
#(
    parameter int PRICE_UNITS      = 4,
    parameter int MAX_CREDIT_UNITS = 8,
    parameter int DISPENSE_CYCLES  = 2,
    parameter int CREDIT_W         = $clog2(MAX_CREDIT_UNITS + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                money_in025,
    input  logic                money_in05,
    input  logic                money_in1,
    input  logic                cancel,
    output logic                sai_cafe,
    output logic                coin_out025,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    // One spare bit keeps credit + coins from wrapping; at least 4 bits so a
    // 7-unit coin sum fits even for tiny credit ceilings.
    localparam int SUM_W = (CREDIT_W + 1 > 4) ? CREDIT_W + 1 : 4;
    localparam int TMR_W = $clog2(DISPENSE_CYCLES + 1);

    state_t              state_d, state_q;
    logic [CREDIT_W-1:0] credit_d, credit_q;
    logic                sai_cafe_q, coin_out025_q, coin_reject_q, busy_q;
    logic                coin_reject_d;
    logic                tmr_load, tmr_done;
    logic [2:0]          sum;
    logic [SUM_W-1:0]    sum_ext;

    vend_pulse_timer #(.CNT_W(TMR_W)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (TMR_W'(DISPENSE_CYCLES - 1)),
        .en       (state_q == DISPENSE),
        .done     (tmr_done)
    );

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        coin_reject_d = 1'b0;
        tmr_load      = 1'b0;
        sum           = coin_sum(money_in025, money_in05, money_in1);
        sum_ext       = SUM_W'(credit_q) + SUM_W'(sum);

        case (state_q)
            IDLE, COLLECT: begin
                if (cancel) begin
                    // Cancel wins over any coin on the same edge.
                    coin_reject_d = (sum != 3'd0);
                    if (credit_q != '0) state_d = CHANGE;
                end else if (sum != 3'd0) begin
                    if (sum_ext > SUM_W'(MAX_CREDIT_UNITS)) begin
                        coin_reject_d = 1'b1;
                    end else if (sum_ext >= SUM_W'(PRICE_UNITS)) begin
                        credit_d = CREDIT_W'(sum_ext - SUM_W'(PRICE_UNITS));
                        state_d  = DISPENSE;
                        tmr_load = 1'b1;
                    end else begin
                        credit_d = CREDIT_W'(sum_ext);
                        state_d  = COLLECT;
                    end
                end
            end
            DISPENSE: begin
                coin_reject_d = (sum != 3'd0);
                if (tmr_done) state_d = (credit_q != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                coin_reject_d = (sum != 3'd0);
                // Credit doubles as the change counter; the pulse for the last
                // unit ends on the edge that empties it.
                if (credit_q <= CREDIT_W'(1)) begin
                    credit_d = '0;
                    state_d  = IDLE;
                end else begin
                    credit_d = credit_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            credit_q      <= '0;
            sai_cafe_q    <= 1'b0;
            coin_out025_q <= 1'b0;
            coin_reject_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            sai_cafe_q    <= (state_d == DISPENSE);
            coin_out025_q <= (state_d == CHANGE);
            coin_reject_q <= coin_reject_d;
            busy_q        <= (state_d == DISPENSE) || (state_d == CHANGE);
        end
    end

    assign sai_cafe    = sai_cafe_q;
    assign coin_out025 = coin_out025_q;
    assign coin_reject = coin_reject_q;
    assign credit      = credit_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_coffee_vend_ctrl.sv
module tb_coffee_vend_ctrl;

    localparam int PRICE = 4;
    localparam int MAXC  = 8;
    localparam int DCYC  = 2;
    localparam int CW    = $clog2(MAXC + 1);

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          money_in025 = 1'b0, money_in05 = 1'b0, money_in1 = 1'b0, cancel = 1'b0;
    logic          sai_cafe, coin_out025, coin_reject, busy;
    logic [CW-1:0] credit;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    coffee_vend_ctrl #(
        .PRICE_UNITS      (PRICE),
        .MAX_CREDIT_UNITS (MAXC),
        .DISPENSE_CYCLES  (DCYC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .money_in025 (money_in025),
        .money_in05  (money_in05),
        .money_in1   (money_in1),
        .cancel      (cancel),
        .sai_cafe    (sai_cafe),
        .coin_out025 (coin_out025),
        .coin_reject (coin_reject),
        .credit      (credit),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    // Behavioural model: credit plus "cycles of dispensing left" plus a
    // "returning change" flag; outputs follow directly from those.
    int m_credit = 0;
    int m_disp   = 0;
    bit m_chg    = 1'b0;
    bit m_rej    = 1'b0;

    always @(posedge clock or negedge reset) begin
        int s, c, d;
        bit ch, r;
        if (!reset) begin
            m_credit <= 0;
            m_disp   <= 0;
            m_chg    <= 1'b0;
            m_rej    <= 1'b0;
        end else begin
            s  = int'(money_in025) + 2 * int'(money_in05) + 4 * int'(money_in1);
            c  = m_credit;
            d  = m_disp;
            ch = m_chg;
            r  = 1'b0;
            if (d > 0) begin
                r = (s > 0);
                d = d - 1;
                if (d == 0 && c > 0) ch = 1'b1;
            end else if (ch) begin
                r = (s > 0);
                c = c - 1;
                if (c == 0) ch = 1'b0;
            end else if (cancel) begin
                r = (s > 0);
                if (c > 0) ch = 1'b1;
            end else if (s > 0) begin
                if (c + s > MAXC) r = 1'b1;
                else if (c + s >= PRICE) begin
                    c = c + s - PRICE;
                    d = DCYC;
                end else c = c + s;
            end
            m_credit <= c;
            m_disp   <= d;
            m_chg    <= ch;
            m_rej    <= r;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clock) begin
        if (check_en) begin
            chk("model.sai_cafe",    int'(sai_cafe),    int'(m_disp > 0));
            chk("model.coin_out025", int'(coin_out025), int'(m_chg));
            chk("model.coin_reject", int'(coin_reject), int'(m_rej));
            chk("model.busy",        int'(busy),        int'((m_disp > 0) || m_chg));
            chk("model.credit",      int'(credit),      m_credit);
            chk("model.exclusive",   int'(sai_cafe && coin_out025), 0);
        end
    end

    // Called at a falling edge: apply inputs, let one rising edge sample them,
    // return at the next falling edge.
    task automatic drive(input logic q, input logic h, input logic o, input logic cn);
        money_in025 = q;
        money_in05  = h;
        money_in1   = o;
        cancel      = cn;
        @(negedge clock);
        money_in025 = 1'b0;
        money_in05  = 1'b0;
        money_in1   = 1'b0;
        cancel      = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic async_reset_pulse(input string tag);
        #1 reset = 1'b0;
        #1;
        chk({tag, ".sai"},    int'(sai_cafe),    0);
        chk({tag, ".coin"},   int'(coin_out025), 0);
        chk({tag, ".busy"},   int'(busy),        0);
        chk({tag, ".credit"}, int'(credit),      0);
        chk({tag, ".reject"}, int'(coin_reject), 0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk("reset.sai",    int'(sai_cafe),    0);
        chk("reset.coin",   int'(coin_out025), 0);
        chk("reset.reject", int'(coin_reject), 0);
        chk("reset.busy",   int'(busy),        0);
        chk("reset.credit", int'(credit),      0);
        reset = 1'b1;
        check_en = 1'b1;

        // 1: four quarters
        drive(1, 0, 0, 0); chk("t1.credit1", int'(credit), 1);
        drive(1, 0, 0, 0); chk("t1.credit2", int'(credit), 2);
        drive(1, 0, 0, 0); chk("t1.credit3", int'(credit), 3);
        drive(1, 0, 0, 0); chk("t1.sai_on", int'(sai_cafe), 1); chk("t1.credit0", int'(credit), 0);
        idle(1);           chk("t1.sai_2nd", int'(sai_cafe), 1);
        idle(1);           chk("t1.sai_off", int'(sai_cafe), 0); chk("t1.nochange", int'(coin_out025), 0);
                           chk("t1.idle", int'(busy), 0);

        // 2: 0.50 then 1.00 -> dispense with 2 units change
        drive(0, 1, 0, 0); chk("t2.credit2", int'(credit), 2);
        drive(0, 0, 1, 0); chk("t2.sai_on", int'(sai_cafe), 1); chk("t2.credit", int'(credit), 2);
        idle(1);           chk("t2.sai_2nd", int'(sai_cafe), 1);
        idle(1);           chk("t2.chg1", int'(coin_out025), 1); chk("t2.sai_off", int'(sai_cafe), 0);
        idle(1);           chk("t2.chg2", int'(coin_out025), 1); chk("t2.credit1", int'(credit), 1);
        idle(1);           chk("t2.chg_end", int'(coin_out025), 0); chk("t2.credit0", int'(credit), 0);

        // 3: two quarters then cancel
        drive(1, 0, 0, 0); drive(1, 0, 0, 0);
        drive(0, 0, 0, 1); chk("t3.chg1", int'(coin_out025), 1); chk("t3.nosai", int'(sai_cafe), 0);
        idle(1);           chk("t3.chg2", int'(coin_out025), 1);
        idle(1);           chk("t3.done", int'(coin_out025), 0); chk("t3.credit0", int'(credit), 0);

        // Cancel with zero credit: ignored, coin still rejected
        drive(1, 0, 0, 1); chk("tc.reject", int'(coin_reject), 1); chk("tc.credit", int'(credit), 0);
                           chk("tc.busy", int'(busy), 0);

        // 4: all coins together, then overflow with 3 preloaded
        drive(1, 1, 1, 0); chk("t4.sai_on", int'(sai_cafe), 1); chk("t4.credit3", int'(credit), 3);
        idle(5);           chk("t4.drained", int'(credit), 0); chk("t4.idle", int'(busy), 0);
        drive(1, 0, 0, 0); drive(1, 0, 0, 0); drive(1, 0, 0, 0);
        drive(1, 1, 1, 0); chk("t4.ovf_reject", int'(coin_reject), 1); chk("t4.ovf_credit", int'(credit), 3);
        idle(1);           chk("t4.reject_pulse", int'(coin_reject), 0);
        drive(0, 0, 0, 1); idle(3); chk("t4.refund_done", int'(credit), 0);

        // 5: coin during dispense is rejected, timing unchanged
        drive(0, 0, 1, 0); chk("t5.sai_on", int'(sai_cafe), 1);
        drive(0, 0, 1, 0); chk("t5.reject", int'(coin_reject), 1); chk("t5.sai_2nd", int'(sai_cafe), 1);
                           chk("t5.credit", int'(credit), 0);
        idle(1);           chk("t5.sai_off", int'(sai_cafe), 0); chk("t5.reject_off", int'(coin_reject), 0);

        // 6: async reset mid-DISPENSE and mid-CHANGE
        drive(1, 0, 0, 0);
        drive(0, 0, 1, 0); chk("t6.disp", int'(sai_cafe), 1); chk("t6.credit1", int'(credit), 1);
        async_reset_pulse("t6.rst_disp");
        drive(1, 0, 0, 0); drive(1, 0, 0, 0); drive(0, 0, 0, 1);
        idle(1);           chk("t6.mid_chg", int'(coin_out025), 1);
        async_reset_pulse("t6.rst_chg");
        drive(0, 0, 1, 0); chk("t6.fresh_sai", int'(sai_cafe), 1); chk("t6.fresh_credit", int'(credit), 0);
        idle(2);           chk("t6.fresh_done", int'(busy), 0);

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
